// File: rtl/tile_renderer.sv
// Tile-map background renderer: frame-latched scroll with wrap, tile-map RAM,
// rotation by ROM address transform, colour-key fill; fixed 5-cycle pipeline.
module tile_renderer #(
  parameter int TILE_SIZE      = 32,
  parameter int NUM_TILES_X    = 40,
  parameter int NUM_TILES_Y    = 25,
  parameter int TILE_IDX_WIDTH = 5,
  parameter int NUM_TILE_TYPES = 8,
  parameter int COLOR_WIDTH    = 12,
  parameter logic [COLOR_WIDTH-1:0] TRANSPARENT = 12'hF0F,
  localparam int LOC_W  = 2*$clog2(TILE_SIZE),
  localparam int ROM_AW = TILE_IDX_WIDTH + LOC_W,
  localparam int CH     = COLOR_WIDTH/3,
  localparam int TX_W   = $clog2(NUM_TILES_X),
  localparam int TY_W   = $clog2(NUM_TILES_Y)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [10:0]                 curr_x,
  input  logic [9:0]                  curr_y,
  input  logic [10:0]                 scroll_x,
  input  logic [9:0]                  scroll_y,
  input  logic [COLOR_WIDTH-1:0]      bg_color,
  input  logic                        tm_we,
  input  logic [TX_W-1:0]             tm_x,
  input  logic [TY_W-1:0]             tm_y,
  input  logic [TILE_IDX_WIDTH+1:0]   tm_wdata,
  output logic [ROM_AW-1:0]           rom_addr,
  input  logic [COLOR_WIDTH-1:0]      rom_data,
  output logic                        o_valid,
  output logic [CH-1:0]               o_pix_r,
  output logic [CH-1:0]               o_pix_g,
  output logic [CH-1:0]               o_pix_b
);

  localparam int LOG_T = $clog2(TILE_SIZE);
  localparam int MAP_W = NUM_TILES_X * TILE_SIZE;
  localparam int MAP_H = NUM_TILES_Y * TILE_SIZE;
  localparam int DEPTH = NUM_TILES_X * NUM_TILES_Y;
  localparam int MA_W  = $clog2(DEPTH);
  localparam int ENT_W = TILE_IDX_WIDTH + 2;

  localparam logic [11:0]             MAP_W_C = 12'(MAP_W);
  localparam logic [11:0]             MAP_H_C = 12'(MAP_H);
  localparam logic [LOG_T-1:0]        N_C     = LOG_T'(TILE_SIZE - 1);
  localparam logic [TILE_IDX_WIDTH:0] NTT_C   = (TILE_IDX_WIDTH+1)'(NUM_TILE_TYPES);

  // Single conditional subtract: both operands are below the limit on-map.
  function automatic logic [11:0] wrap_add(input logic [11:0] a,
                                           input logic [11:0] b,
                                           input logic [11:0] lim);
    logic [11:0] sum;
    sum = a + b;
    return (sum >= lim) ? (sum - lim) : sum;
  endfunction

  // Stage 0 (combinational)
  logic                 frame_start_s;
  logic [10:0]          sx_q, sx_d;
  logic [9:0]           sy_q, sy_d;
  logic [11:0]          wx_s, wy_s;
  logic                 off_s;
  logic [MA_W-1:0]      rd_addr_s, wr_addr_s;
  logic                 wr_en_s;

  // Pipeline registers
  logic                 v1_q, off1_q;
  logic [LOG_T-1:0]     lx1_q, ly1_q;
  logic [ENT_W-1:0]     tmap_rd_q;
  logic                 v2_q, off2_q;
  logic [LOG_T-1:0]     lx2_q, ly2_q;
  logic [ENT_W-1:0]     ent2_q;
  logic                 v3_q, fill3_q, fill3_d;
  logic [ROM_AW-1:0]    rom_addr_q, rom_addr_d;
  logic                 v4_q, fill4_q;
  logic                 o_valid_q;
  logic [COLOR_WIDTH-1:0] pix_q, pix_d;

  // Stage 2 (combinational)
  logic [TILE_IDX_WIDTH-1:0] idx_s;
  logic [1:0]                rot_s;
  logic [LOG_T-1:0]          row_s, col_s;
  logic                      bad_idx_s;

  logic [ENT_W-1:0] tmap_mem [DEPTH];

  // Frame-start scroll bypass, world-coordinate wrap and tile-map addressing.
  always_comb begin
    frame_start_s = in_valid && (curr_x == 11'd0) && (curr_y == 10'd0);
    sx_d = sx_q;
    sy_d = sy_q;
    if (frame_start_s && ({1'b0, scroll_x} < MAP_W_C)) begin
      sx_d = scroll_x;
    end else begin
      sx_d = sx_q;
    end
    if (frame_start_s && ({2'b00, scroll_y} < MAP_H_C)) begin
      sy_d = scroll_y;
    end else begin
      sy_d = sy_q;
    end
    wx_s  = wrap_add({1'b0, curr_x}, {1'b0, sx_d}, MAP_W_C);
    wy_s  = wrap_add({2'b00, curr_y}, {2'b00, sy_d}, MAP_H_C);
    off_s = ({1'b0, curr_x} >= MAP_W_C) || ({2'b00, curr_y} >= MAP_H_C);
    // Off-map world coordinates can exceed the map, so park the read address.
    if (off_s) begin
      rd_addr_s = {MA_W{1'b0}};
    end else begin
      rd_addr_s = MA_W'(32'(wy_s >> LOG_T) * 32'(NUM_TILES_X) + 32'(wx_s >> LOG_T));
    end
    wr_en_s   = tm_we && (32'(tm_x) < 32'(NUM_TILES_X)) && (32'(tm_y) < 32'(NUM_TILES_Y));
    wr_addr_s = MA_W'(32'(tm_y) * 32'(NUM_TILES_X) + 32'(tm_x));
  end

  // Tile-map RAM: independent write port, read-first synchronous read; not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      tmap_mem[wr_addr_s] <= tm_wdata;
    end
    tmap_rd_q <= tmap_mem[rd_addr_s];
  end

  // Rotation as an address transform on the tile-local coordinates.
  always_comb begin
    idx_s = ent2_q[TILE_IDX_WIDTH-1:0];
    rot_s = ent2_q[ENT_W-1 -: 2];
    row_s = ly2_q;
    col_s = lx2_q;
    case (rot_s)
      2'd0: begin row_s = ly2_q;          col_s = lx2_q;          end
      2'd1: begin row_s = N_C - lx2_q;    col_s = ly2_q;          end
      2'd2: begin row_s = N_C - ly2_q;    col_s = N_C - lx2_q;    end
      2'd3: begin row_s = lx2_q;          col_s = N_C - ly2_q;    end
      default: begin row_s = ly2_q;       col_s = lx2_q;          end
    endcase
    bad_idx_s  = ({1'b0, idx_s} >= NTT_C);
    rom_addr_d = {idx_s, row_s, col_s};
    fill3_d    = off2_q || bad_idx_s;
  end

  // Output select; bubbles hold the previous pixel.
  always_comb begin
    pix_d = pix_q;
    if (v4_q) begin
      if (fill4_q || (rom_data == TRANSPARENT)) begin
        pix_d = bg_color;
      end else begin
        pix_d = rom_data;
      end
    end else begin
      pix_d = pix_q;
    end
  end

  // Scroll state and pipeline stages, flushed by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sx_q       <= 11'd0;
      sy_q       <= 10'd0;
      v1_q       <= 1'b0;
      off1_q     <= 1'b0;
      lx1_q      <= {LOG_T{1'b0}};
      ly1_q      <= {LOG_T{1'b0}};
      v2_q       <= 1'b0;
      off2_q     <= 1'b0;
      lx2_q      <= {LOG_T{1'b0}};
      ly2_q      <= {LOG_T{1'b0}};
      ent2_q     <= {ENT_W{1'b0}};
      v3_q       <= 1'b0;
      fill3_q    <= 1'b0;
      rom_addr_q <= {ROM_AW{1'b0}};
      v4_q       <= 1'b0;
      fill4_q    <= 1'b0;
      o_valid_q  <= 1'b0;
      pix_q      <= {COLOR_WIDTH{1'b0}};
    end else begin
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      v1_q       <= in_valid;
      off1_q     <= off_s;
      lx1_q      <= wx_s[LOG_T-1:0];
      ly1_q      <= wy_s[LOG_T-1:0];
      v2_q       <= v1_q;
      off2_q     <= off1_q;
      lx2_q      <= lx1_q;
      ly2_q      <= ly1_q;
      ent2_q     <= tmap_rd_q;
      v3_q       <= v2_q;
      fill3_q    <= fill3_d;
      rom_addr_q <= rom_addr_d;
      v4_q       <= v3_q;
      fill4_q    <= fill3_q;
      o_valid_q  <= v4_q;
      pix_q      <= pix_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign o_valid  = o_valid_q;
  assign o_pix_r  = pix_q[COLOR_WIDTH-1 -: CH];
  assign o_pix_g  = pix_q[2*CH-1 -: CH];
  assign o_pix_b  = pix_q[CH-1:0];

endmodule

// File: tb/tb_tile_renderer.sv
// Bench for tile_renderer: directed vector table, hand-written corner sequences
// and random traffic scored against an arithmetic model of the renderer.
module tb_tile_renderer;

  localparam int TS    = 32;
  localparam int NX    = 40;
  localparam int NY    = 25;
  localparam int NTT   = 8;
  localparam int MAP_W = NX*TS;
  localparam int MAP_H = NY*TS;
  localparam logic [11:0] TRANS = 12'hF0F;
  localparam logic [11:0] BG    = 12'h3C6;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [10:0] curr_x;
  logic [9:0]  curr_y;
  logic [10:0] scroll_x;
  logic [9:0]  scroll_y;
  logic [11:0] bg_color;
  logic        tm_we;
  logic [5:0]  tm_x;
  logic [4:0]  tm_y;
  logic [6:0]  tm_wdata;
  logic [14:0] rom_addr;
  logic [11:0] rom_data;
  logic        o_valid;
  logic [3:0]  o_pix_r, o_pix_g, o_pix_b;

  tile_renderer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .curr_x(curr_x), .curr_y(curr_y),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .bg_color(bg_color),
    .tm_we(tm_we), .tm_x(tm_x), .tm_y(tm_y), .tm_wdata(tm_wdata),
    .rom_addr(rom_addr), .rom_data(rom_data), .o_valid(o_valid),
    .o_pix_r(o_pix_r), .o_pix_g(o_pix_g), .o_pix_b(o_pix_b)
  );

  always #5 clk = ~clk;

  // Tile ROM contents: texels with local column 19 are the colour key.
  function automatic logic [11:0] rom_fn(input logic [14:0] a);
    logic [11:0] t;
    t = 12'(a * 15'd7) ^ 12'h5A5;
    if (a[4:0] == 5'd19) return TRANS;
    else if (t == TRANS) return 12'h0F0;
    else return t;
  endfunction

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  typedef struct {
    bit          v;
    bit          chk;
    logic [14:0] addr;
    logic [11:0] pix;
  } exp_t;

  typedef struct {
    logic [6:0] ent;
    int         x;
    int         y;
    bit         chk_addr;
    int         exp_addr;
    bit         exp_bg;
  } vec_t;

  logic [6:0]  mmap [NX*NY];
  int          m_sx, m_sy;
  logic [11:0] last_pix;
  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    int wx, wy, lx, ly, row, col, idx, rot;
    logic [6:0]  ent;
    logic [11:0] tex;
    e.v = 1'b1; e.chk = 1'b0; e.addr = 15'd0; e.pix = BG;
    if (x >= MAP_W || y >= MAP_H) return e;
    wx  = (x + m_sx) % MAP_W;
    wy  = (y + m_sy) % MAP_H;
    ent = mmap[(wy / TS) * NX + (wx / TS)];
    idx = int'(ent[4:0]);
    rot = int'(ent[6:5]);
    lx  = wx % TS;
    ly  = wy % TS;
    case (rot)
      0:       begin row = ly;          col = lx;          end
      1:       begin row = TS - 1 - lx; col = ly;          end
      2:       begin row = TS - 1 - ly; col = TS - 1 - lx; end
      default: begin row = lx;          col = TS - 1 - ly; end
    endcase
    if (idx >= NTT) return e;
    e.chk  = 1'b1;
    e.addr = 15'(idx*TS*TS + row*TS + col);
    tex    = rom_fn(e.addr);
    e.pix  = (tex == TRANS) ? BG : tex;
    return e;
  endfunction

  // One clock: predict the current input, advance, then score the pipeline taps.
  task automatic step();
    exp_t e, o;
    if (!rst) begin
      @(posedge clk); #1;
      check("reset_valid", o_valid, 0);
      check("reset_pix", {o_pix_r, o_pix_g, o_pix_b}, 0);
      check("reset_rom_addr", rom_addr, 0);
      sbq.delete();
      e = '{v: 1'b0, chk: 1'b0, addr: 15'd0, pix: 12'd0};
      for (int i = 0; i < 4; i++) sbq.push_back(e);
      m_sx = 0; m_sy = 0; last_pix = 12'd0;
    end else begin
      e = '{v: 1'b0, chk: 1'b0, addr: 15'd0, pix: 12'd0};
      if (in_valid) begin
        if (curr_x == 11'd0 && curr_y == 10'd0) begin
          if (int'(scroll_x) < MAP_W) m_sx = int'(scroll_x);
          if (int'(scroll_y) < MAP_H) m_sy = int'(scroll_y);
        end
        e = model(int'(curr_x), int'(curr_y));
      end
      sbq.push_back(e);
      if (tm_we && int'(tm_x) < NX && int'(tm_y) < NY)
        mmap[int'(tm_y)*NX + int'(tm_x)] = tm_wdata;
      @(posedge clk); #1;
      if (sbq.size() >= 3 && sbq[sbq.size()-3].chk)
        check("sb_rom_addr", rom_addr, sbq[sbq.size()-3].addr);
      if (sbq.size() == 5) begin
        o = sbq.pop_front();
        check("sb_valid", o_valid, o.v);
        if (o.v) last_pix = o.pix;
        check("sb_pix", {o_pix_r, o_pix_g, o_pix_b}, last_pix);
      end
    end
  endtask

  task automatic write_tile(input int x, input int y, input logic [6:0] d);
    in_valid = 1'b0; tm_we = 1'b1; tm_x = 6'(x); tm_y = 5'(y); tm_wdata = d;
    step();
    tm_we = 1'b0;
  endtask

  task automatic pix_step(input int x, input int y);
    in_valid = 1'b1; curr_x = 11'(x); curr_y = 10'(y);
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{7'h01,  100,  70, 1'b1, 1220, 1'b0};
    tbl[1]  = '{7'h21,  100,  70, 1'b1, 1894, 1'b0};
    tbl[2]  = '{7'h41,  100,  70, 1'b1, 1851, 1'b0};
    tbl[3]  = '{7'h61,  100,  70, 1'b1, 1177, 1'b0};
    tbl[4]  = '{7'h01,  115,  70, 1'b1, 1235, 1'b1};
    tbl[5]  = '{7'h09,  100,  70, 1'b0,    0, 1'b1};
    tbl[6]  = '{7'h01, 1280,  70, 1'b0,    0, 1'b1};
    tbl[7]  = '{7'h01,   10, 800, 1'b0,    0, 1'b1};
    tbl[8]  = '{7'h07,  100,  70, 1'b1, 7364, 1'b0};
    tbl[9]  = '{7'h08,  100,  70, 1'b0,    0, 1'b1};
    tbl[10] = '{7'h02,  127,  95, 1'b1, 3071, 1'b0};

    rst = 1'b0; in_valid = 1'b0; curr_x = 11'd5; curr_y = 10'd5;
    scroll_x = 11'd0; scroll_y = 10'd0; bg_color = BG;
    tm_we = 1'b0; tm_x = 6'd0; tm_y = 5'd0; tm_wdata = 7'd0;
    m_sx = 0; m_sy = 0; last_pix = 12'd0;
    step(); step();
    rst = 1'b1;

    for (int t = 0; t < NX*NY; t++) write_tile(t % NX, t / NX, 7'($urandom));

    // Directed vectors through tile (3,2)
    for (int i = 0; i < 11; i++) begin
      write_tile(3, 2, tbl[i].ent);
      pix_step(tbl[i].x, tbl[i].y);
      idle(2);
      if (tbl[i].chk_addr) check("tbl_rom_addr", rom_addr, tbl[i].exp_addr);
      idle(2);
      check("tbl_valid", o_valid, 1);
      check("tbl_pix", {o_pix_r, o_pix_g, o_pix_b},
            tbl[i].exp_bg ? BG : rom_fn(15'(tbl[i].exp_addr)));
    end

    // Scroll wrap, frame latching and rejection of an out-of-range request
    write_tile(0, 0, 7'h03);
    write_tile(39, 0, 7'h04);
    scroll_x = 11'd1270; scroll_y = 10'd0;
    pix_step(0, 0);
    idle(2);
    check("wrap_frame_start", rom_addr, 4118);
    pix_step(20, 0);
    idle(2);
    check("wrap_x", rom_addr, 3082);
    scroll_x = 11'd0;
    pix_step(20, 1);
    idle(2);
    check("latch_hold", rom_addr, 3114);
    scroll_x = 11'd1300;
    pix_step(0, 0);
    idle(2);
    check("reject_keep", rom_addr, 4118);
    idle(3);

    // Same-cycle tile-map write and read
    scroll_x = 11'd0; scroll_y = 10'd0;
    in_valid = 1'b1; curr_x = 11'd0; curr_y = 10'd0;
    tm_we = 1'b1; tm_x = 6'd0; tm_y = 5'd0; tm_wdata = 7'h05;
    step();
    tm_we = 1'b0;
    pix_step(1, 0);
    idle(1);
    check("collide_old", rom_addr, 3072);
    idle(1);
    check("collide_new", rom_addr, 5121);
    idle(4);

    // Scroll limits at the map edge, scored by the model
    scroll_x = 11'd1280; scroll_y = 10'd799;
    pix_step(0, 0); pix_step(5, 3); pix_step(40, 1);
    scroll_x = 11'd1279; scroll_y = 10'd800;
    pix_step(0, 0); pix_step(1, 0); pix_step(2, 799);
    idle(6);

    // Reset with pixels in flight, then a bubble pattern
    pix_step(5, 5); pix_step(6, 5); pix_step(7, 5);
    in_valid = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    idle(1);
    check("rst_flush_valid", o_valid, 0);
    pix_step(9, 9);
    idle(1);
    pix_step(10, 9);
    idle(6);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      in_valid = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 24) == 0) begin
        curr_x = 11'd0; curr_y = 10'd0;
      end else begin
        curr_x = 11'($urandom_range(0, 1400));
        curr_y = 10'($urandom_range(0, 860));
      end
      scroll_x = 11'($urandom_range(0, 1400));
      scroll_y = 10'($urandom_range(0, 900));
      tm_we    = ($urandom_range(0, 3) == 0);
      tm_x     = 6'($urandom_range(0, NX-1));
      tm_y     = 5'($urandom_range(0, NY-1));
      tm_wdata = 7'($urandom);
      step();
    end
    tm_we = 1'b0;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
